// File: rtl/eth_udp_demux_if.sv
// Beat-stream input and shared channel-write output bundle for eth_udp_demux.
// The master side drives the Ethernet beats and FIFO-full flags. The slave side is the demux.
interface eth_udp_demux_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 32
);
    logic              eth_tvalid;
    logic              eth_tlast;
    logic [7:0]        eth_tkeep;
    logic [63:0]       eth_tdata;
    logic [NUM_CH-1:0] ch_full;

    logic [NUM_CH-1:0] ch_wr_en;
    logic [63:0]       out_tdata;
    logic [7:0]        out_tkeep;
    logic              out_tlast;
    logic              out_dvalid;
    logic [CNT_W-1:0]  cnt_rx;
    logic [CNT_W-1:0]  cnt_drop;
    logic [CNT_W-1:0]  cnt_trunc;

    modport master (
        output eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, ch_full,
        input  ch_wr_en, out_tdata, out_tkeep, out_tlast, out_dvalid,
        input  cnt_rx, cnt_drop, cnt_trunc
    );

    modport slave (
        input  eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, ch_full,
        output ch_wr_en, out_tdata, out_tkeep, out_tlast, out_dvalid,
        output cnt_rx, cnt_drop, cnt_trunc
    );
endinterface

// File: rtl/eth_udp_demux.sv
// Ethernet/IPv4/UDP demultiplexer: filters 64-bit beat frames on EtherType/IP/UDP port
// and writes the payload to one of NUM_CH FIFO channels in stream or record mode.
module eth_udp_demux #(
    parameter logic [15:0]          ETH_PROTO = 16'h0800,
    parameter logic [31:0]          LOCAL_IP  = 32'hC0A80A01,
    parameter logic [31:0]          PEER_IP   = 32'hC0A80A03,
    parameter int unsigned          NUM_CH    = 3,
    parameter logic [NUM_CH*16-1:0] CH_PORT   = {16'h3000, 16'h4002, 16'h4001},
    parameter logic [NUM_CH*16-1:0] CH_MASK   = {16'hF000, 16'hFFFF, 16'hFFFF},
    parameter logic [NUM_CH-1:0]    CH_MODE   = 3'b011,
    parameter int unsigned          BUBBLE_N  = 4,
    parameter int unsigned          CNT_W     = 32
) (
    input logic            eth_clk,
    input logic            eth_rst,
    eth_udp_demux_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_STREAM, S_RECORD, S_BUBBLE, S_TRUNC, S_DRAIN
    } state_t;

    localparam logic [15:0] BUB_LAST = 16'(BUBBLE_N - 1);

    state_t            state, state_n;
    logic [2:0]        beat_idx, idx_n;
    logic              hdr_ok, ok_n;
    logic [15:0]       ip_hi, ip_hi_n;
    logic [NUM_CH-1:0] sel_oh, sel_n, match_oh;
    logic [63:0]       hold_data, hold_d_n;
    logic [7:0]        hold_keep, hold_k_n;
    logic              tl_seen, tl_n;
    logic [15:0]       bub_cnt, bub_n;
    logic              inc_rx, inc_drop, inc_trunc;
    logic              wr, wr_ok, o_last, o_dvalid;
    logic [63:0]       o_data;
    logic [7:0]        o_keep;
    logic [CNT_W-1:0]  cnt_rx_q, cnt_drop_q, cnt_trunc_q;

    logic        vld, lst, full_sel, mode_sel, seen, hdr_pass;
    logic [63:0] d;
    logic [15:0] eth_type, udp_dest;
    logic [31:0] src_ip, dst_ip;

    function automatic logic [63:0] swap_halves(input logic [63:0] x);
        return {x[31:0], x[63:32]};
    endfunction

    assign vld      = bus.eth_tvalid;
    assign lst      = bus.eth_tlast;
    assign d        = bus.eth_tdata;
    // Wire byte k of a beat sits at d[8k+7:8k]; fields are rebuilt in network order.
    assign eth_type = {d[39:32], d[47:40]};
    assign src_ip   = {d[23:16], d[31:24], d[39:32], d[47:40]};
    assign dst_ip   = {ip_hi, d[7:0], d[15:8]};
    assign udp_dest = {d[39:32], d[47:40]};
    assign full_sel = |(bus.ch_full & sel_oh);
    assign mode_sel = |(CH_MODE & sel_oh);
    assign seen     = tl_seen | (vld & lst);
    assign hdr_pass = hdr_ok && (dst_ip == LOCAL_IP) && (|match_oh);

    always_comb begin
        logic        found;
        logic [15:0] port_c;
        logic [15:0] mask_c;
        match_oh = '0;
        found    = 1'b0;
        port_c   = '0;
        mask_c   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            port_c = 16'(CH_PORT >> (c * 16));
            mask_c = 16'(CH_MASK >> (c * 16));
            if (!found && ((udp_dest & mask_c) == (port_c & mask_c))) begin
                match_oh = NUM_CH'(1) << c;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = beat_idx;
        ok_n      = hdr_ok;
        ip_hi_n   = ip_hi;
        sel_n     = sel_oh;
        hold_d_n  = hold_data;
        hold_k_n  = hold_keep;
        tl_n      = tl_seen;
        bub_n     = bub_cnt;
        inc_rx    = 1'b0;
        inc_drop  = 1'b0;
        inc_trunc = 1'b0;
        wr        = 1'b0;
        o_data    = '0;
        o_keep    = '0;
        o_last    = 1'b0;
        o_dvalid  = 1'b0;
        case (state)
            S_IDLE: if (vld) begin
                inc_rx = 1'b1;
                tl_n   = 1'b0;
                ok_n   = 1'b1;
                sel_n  = '0;
                if (lst) inc_drop = 1'b1;
                else begin
                    state_n = S_HDR;
                    idx_n   = 3'd1;
                end
            end
            S_HDR: if (vld) begin
                idx_n = beat_idx + 3'd1;
                case (beat_idx)
                    3'd1: ok_n = hdr_ok && (eth_type == ETH_PROTO) && (d[55:48] == 8'h45);
                    3'd2: ok_n = hdr_ok && (d[63:56] == 8'h11);
                    3'd3: begin
                        ok_n    = hdr_ok && (src_ip == PEER_IP);
                        ip_hi_n = {d[55:48], d[63:56]};
                    end
                    3'd4: sel_n = match_oh;
                    default: ;
                endcase
                if (lst && beat_idx != 3'd5) begin
                    state_n  = S_IDLE;
                    inc_drop = 1'b1;
                end else if (beat_idx == 3'd4 && !hdr_pass) begin
                    state_n  = S_DRAIN;
                    inc_drop = 1'b1;
                end else if (beat_idx == 3'd5) begin
                    hold_d_n = d;
                    hold_k_n = bus.eth_tkeep;
                    if (mode_sel) state_n = lst ? S_IDLE : S_RECORD;
                    else if (lst) begin
                        state_n  = S_IDLE;
                        inc_drop = 1'b1;
                    end else state_n = S_STREAM;
                end
            end
            S_STREAM: if (vld) begin
                if (!full_sel) begin
                    wr       = 1'b1;
                    o_data   = swap_halves(d);
                    o_keep   = bus.eth_tkeep;
                    o_last   = lst;
                    o_dvalid = 1'b1;
                    if (lst) state_n = S_IDLE;
                end else begin
                    inc_trunc = 1'b1;
                    tl_n      = lst;
                    state_n   = S_TRUNC;
                end
            end
            S_TRUNC: begin
                tl_n = seen;
                if (!full_sel) begin
                    wr      = 1'b1;
                    o_last  = 1'b1;
                    state_n = seen ? S_IDLE : S_DRAIN;
                end
            end
            S_RECORD: begin
                tl_n = seen;
                if (!full_sel) begin
                    wr       = 1'b1;
                    o_data   = swap_halves(hold_data);
                    o_keep   = hold_keep;
                    o_last   = 1'b1;
                    o_dvalid = 1'b1;
                    bub_n    = '0;
                    if (BUBBLE_N == 0) state_n = seen ? S_IDLE : S_DRAIN;
                    else state_n = S_BUBBLE;
                end else begin
                    inc_trunc = 1'b1;
                    state_n   = seen ? S_IDLE : S_DRAIN;
                end
            end
            S_BUBBLE: begin
                tl_n = seen;
                if (!full_sel) begin
                    wr     = 1'b1;
                    o_data = swap_halves(hold_data);
                    o_keep = hold_keep;
                    if (bub_cnt == BUB_LAST) state_n = seen ? S_IDLE : S_DRAIN;
                    else bub_n = bub_cnt + 16'd1;
                end
            end
            S_DRAIN: if (vld && lst) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state       <= S_IDLE;
            beat_idx    <= '0;
            hdr_ok      <= 1'b0;
            ip_hi       <= '0;
            sel_oh      <= '0;
            hold_data   <= '0;
            hold_keep   <= '0;
            tl_seen     <= 1'b0;
            bub_cnt     <= '0;
            cnt_rx_q    <= '0;
            cnt_drop_q  <= '0;
            cnt_trunc_q <= '0;
        end else begin
            state     <= state_n;
            beat_idx  <= idx_n;
            hdr_ok    <= ok_n;
            ip_hi     <= ip_hi_n;
            sel_oh    <= sel_n;
            hold_data <= hold_d_n;
            hold_keep <= hold_k_n;
            tl_seen   <= tl_n;
            bub_cnt   <= bub_n;
            if (inc_rx && cnt_rx_q != '1)       cnt_rx_q    <= cnt_rx_q + CNT_W'(1);
            if (inc_drop && cnt_drop_q != '1)   cnt_drop_q  <= cnt_drop_q + CNT_W'(1);
            if (inc_trunc && cnt_trunc_q != '1) cnt_trunc_q <= cnt_trunc_q + CNT_W'(1);
        end
    end

    // Reset must silence the write port even while the state register still holds a frame.
    assign wr_ok          = wr & ~eth_rst;
    assign bus.ch_wr_en   = wr_ok ? sel_oh : '0;
    assign bus.out_tdata  = wr_ok ? o_data : '0;
    assign bus.out_tkeep  = wr_ok ? o_keep : '0;
    assign bus.out_tlast  = wr_ok & o_last;
    assign bus.out_dvalid = wr_ok & o_dvalid;
    assign bus.cnt_rx     = cnt_rx_q;
    assign bus.cnt_drop   = cnt_drop_q;
    assign bus.cnt_trunc  = cnt_trunc_q;
endmodule

// File: doc/eth_udp_demux.md
ETH_UDP_DEMUX -- requirements
Module: eth_udp_demux

Interface
REQ-001 SHALL have parameter ETH_PROTO, default 16'h0800, the required EtherType.
REQ-002 SHALL have parameter LOCAL_IP, default 32'hC0A80A01 (192.168.10.1), the required IPv4 destination address.
REQ-003 SHALL have parameter PEER_IP, default 32'hC0A80A03 (192.168.10.3), the required IPv4 source address.
REQ-004 SHALL have parameter NUM_CH, default 3, the number of output channels (1..8).
REQ-005 SHALL have parameters CH_PORT [NUM_CH*16], CH_MASK [NUM_CH*16], CH_MODE [NUM_CH] (0=stream, 1=record); defaults {4001,4002,3000}, {FFFF,FFFF,F000}, {1,1,0}, channel 0 in the LSBs.
REQ-006 SHALL have parameter BUBBLE_N, default 4, the number of filler writes after a record; parameter CNT_W, default 32, the counter width.
REQ-007 eth_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 eth_rst  in  1  reset, synchronous, active-high.
REQ-009 eth_tvalid/eth_tlast  in  1/1  input beat valid / last beat of frame.
REQ-010 eth_tkeep/eth_tdata  in  8/64  byte enables / data; byte 0 of a beat is tdata[7:0], the first on the wire.
REQ-011 ch_wr_en  out  NUM_CH  one-hot FIFO write strobe per channel.
REQ-012 ch_full  in  NUM_CH  per-channel FIFO full.
REQ-013 out_tdata/out_tkeep/out_tlast/out_dvalid  out  64/8/1/1  write data shared by all channels.
REQ-014 cnt_rx/cnt_drop/cnt_trunc  out  CNT_W each  frames started / frames filtered or runt / frames truncated by full.

Function
REQ-015 SHALL process only beats with eth_tvalid=1; idle cycles SHALL not advance any state or beat index.
REQ-016 SHALL number beats 0..N per frame; header = beats 0..5 (wire bytes 0..47).
REQ-017 SHALL check: bytes 12-13 == ETH_PROTO; byte 14 == 8'h45; byte 23 == 8'h11; bytes 26-29 == PEER_IP; bytes 30-33 == LOCAL_IP; multi-byte fields in network order.
REQ-018 Channel c SHALL match when (udp_dest & CH_MASK[c]) == (CH_PORT[c] & CH_MASK[c]), udp_dest = bytes 36-37; the lowest matching index SHALL win.
REQ-019 States: IDLE, HDR, STREAM, RECORD, BUBBLE, TRUNC, DRAIN.
REQ-020 IDLE: first valid beat -> HDR, beat index=1, cnt_rx+1.
REQ-021 HDR: a failed check or no channel match at beat 4 -> DRAIN (cnt_drop+1); eth_tlast on any beat 0..4 -> IDLE (cnt_drop+1).
REQ-022 At beat 5 of a matched frame: stream channel -> STREAM, or IDLE with cnt_drop+1 if tlast; record channel -> RECORD with beat 5 held, or IDLE if tlast.
REQ-023 STREAM: each valid beat with ch_full[c]=0 SHALL assert ch_wr_en[c] same cycle, out_tdata = beat with 32-bit halves swapped ({bytes 3..0, bytes 7..4}), out_tkeep/out_tlast = input, out_dvalid=1; tlast -> IDLE.
REQ-024 STREAM with ch_full[c]=1 on a valid beat: beat discarded, -> TRUNC, cnt_trunc+1.
REQ-025 TRUNC: when ch_full[c]=0, SHALL write one beat out_tlast=1, out_tkeep=0, out_tdata=0, out_dvalid=0; then -> IDLE if input tlast already seen, else DRAIN.
REQ-026 RECORD: ch_full[c]=0 -> write held beat 5 (swapped) with out_dvalid=1, out_tlast=1, -> BUBBLE; ch_full[c]=1 -> drop record, cnt_trunc+1, -> DRAIN or IDLE.
REQ-027 BUBBLE: SHALL write held beat with out_dvalid=0 on each cycle ch_full[c]=0 until BUBBLE_N writes done, then -> DRAIN, or IDLE if tlast seen.
REQ-028 DRAIN: discard beats until eth_tlast, then -> IDLE.
REQ-029 Input tlast seen in TRUNC/RECORD/BUBBLE SHALL be latched; beats there are discarded.
REQ-030 ch_wr_en SHALL be zero when not writing; data outputs 0 when ch_wr_en==0.
REQ-031 Counters SHALL saturate at all-ones; simultaneous increments of different counters SHALL all apply.

Reset
REQ-032 eth_rst=1 SHALL force IDLE, counters 0, held beat/latched tlast 0, all outputs 0, overriding any frame in progress; a frame cut by reset is not counted.
REQ-033 After reset deasserts mid-frame, beats SHALL be parsed as a new frame; runt/filter rules apply.

Verification
REQ-034 Valid frame, dest 0x3005, 9 beats, no full -> ch_wr_en[2] on beats 6-8 only, tlast on beat 8, cnt_rx=1.
REQ-035 Dest 0x4002, 8 beats -> one write ch1 dvalid=1 tlast=1 data=swapped beat 5, then 4 writes dvalid=0, cnt_drop=0.
REQ-036 EtherType 0x0806 then valid frame -> no writes for first, cnt_drop=1, second forwarded normally.
REQ-037 ch_full[2]=1 on beat 7 of 12, released 3 cycles later -> 1 data write, one tlast/tkeep=0 write, beats 8-11 discarded, cnt_trunc=1.
REQ-038 Frame with tlast at beat 3, tvalid gaps in frames, eth_rst asserted at beat 6 of stream frame -> runt counted, gaps ignored, outputs 0 and counters 0 after reset.
